tag_pool_ctrl: RTL and testbench
================================

// Module: tag_pool_ctrl
// PURPOSE
//  Parametrised tag allocator with per-tag metadata store for the PSL command path.
//  Owns a free-list of NUM_TAGS tags and hands one out per granted command.
//  Stores META_WIDTH bits of command metadata against that tag, and returns the
//  metadata one cycle after the matching response releases the tag.
//  Sits between the command arbiter (allocate side) and response control (release side).
// PARAMETERS
//  TAG_WIDTH   8    tag bits; NUM_TAGS <= 2**TAG_WIDTH
//  NUM_TAGS    64   tags in pool; any value 2..2**TAG_WIDTH, not required to be a power of 2
//  META_WIDTH  128  metadata bits stored per tag (packed command tag line)
// PORTS
//  clock          in   1           rising-edge clock
//  rstn           in   1           async active-low reset
//  enabled        in   1           start init / keep pool alive
//  alloc_req      in   1           command wants a tag
//  alloc_meta     in   META_WIDTH  metadata written on grant
//  alloc_gnt      out  1           tag granted this cycle (combinational)
//  alloc_tag      out  TAG_WIDTH   granted tag (head of free-list, registered)
//  rel_valid      in   1           response returns a tag
//  rel_tag        in   TAG_WIDTH   returned tag
//  rel_tag_parity in   1           odd parity over rel_tag (used only with macro)
//  rel_meta_valid out  1           metadata valid, 1 cycle after rel_valid
//  rel_meta       out  META_WIDTH  metadata of released tag
//  rel_tag_out    out  TAG_WIDTH   released tag echo
//  tag_ready      out  1           state READY and free_count != 0
//  free_count     out  TAG_WIDTH+1 tags currently free
//  init_done      out  1           pool initialised
//  err_release    out  1           sticky: release of tag not in flight
//  err_parity     out  1           sticky: release tag parity error (macro only, else 0)
// BEHAVIOUR
//  Clock/reset: single clock; reset is asynchronous, active-low (rstn).
//  Reset: all outputs 0, free_count=0, in-flight vector cleared, state RESET.
//  FSM: RESET -(enabled)-> INIT -(NUM_TAGS pushes done)-> READY;
//   any state -(!enabled)-> RESET; all pending tags discarded on exit.
//  INIT: pushes tags 0,1,..,NUM_TAGS-1 into free FIFO, one per cycle.
//   Takes NUM_TAGS cycles; init_done rises the cycle READY is entered.
//   free_count == NUM_TAGS at that point.
//  Allocate: alloc_gnt = alloc_req & tag_ready.
//   On grant: alloc_tag popped; meta[alloc_tag]<=alloc_meta; inflight[tag]<=1.
//   The next free tag appears on alloc_tag the following cycle.
//   Back-to-back grants: one per cycle allowed.
//  Release: when rel_valid & inflight[rel_tag] (and parity OK with macro):
//   inflight<=0; tag pushed to FIFO tail.
//   rel_meta/rel_tag_out registered; rel_meta_valid pulses 1 cycle later.
//   Bad release: no push, rel_meta_valid stays 0, err_release set (sticky until reset).
//   rel_valid outside READY: ignored; err_release set.
//  Simultaneous alloc+release in one cycle: both take effect; free_count unchanged.
//   Grant uses pre-release count: if pool empty, alloc denied that cycle even if a
//   release arrives; the released tag is grantable next cycle.
//  free_count: +1 per push, -1 per pop, saturating never needed (cannot exceed NUM_TAGS).
//  FIFO pointers wrap at NUM_TAGS (explicit compare, not modulo 2**n).
//  Reset mid-operation: in-flight tags lost; pool re-inits after enabled.
// CONFIGURATION
//  TAG_POOL_PARITY_EN defined: rel_tag_parity checked (odd parity over rel_tag).
//   On mismatch: release dropped, err_parity set sticky, err_release unaffected.
//  Not defined: rel_tag_parity ignored, err_parity tied 0.
// TESTING
//  NUM_TAGS=64, enabled=1 after reset -> init_done at cycle 64, free_count=64, alloc_tag=0.
//  64 back-to-back alloc_req -> tags 0..63 granted, tag_ready=0; 65th req gnt=0.
//  Release tag 5 (meta 0xA5..) -> next cycle rel_meta_valid=1, rel_meta=0xA5..,
//   rel_tag_out=5; free_count=1.
//  Pool empty, release tag 9 + alloc_req same cycle -> gnt=0.
//   Next cycle gnt=1, alloc_tag=9.
//  Release tag 7 twice -> second: rel_meta_valid=0, err_release=1, free_count unchanged.
//  Macro on, rel_tag=3 with even parity -> err_parity=1, tag 3 stays in flight.
//  Macro off, same stimulus -> tag 3 released, err_parity=0.
//  rstn low mid-traffic -> outputs 0; re-init restores free_count=64.

Source files
------------

// File: rtl/tag_pool_ctrl.sv
// tag_pool_ctrl: free-list tag allocator with a per-tag metadata store for the command path.
// Optional release-tag odd-parity checking is enabled by defining TAG_POOL_PARITY_EN.
module tag_pool_ctrl #(
  parameter int TAG_WIDTH  = 8,
  parameter int NUM_TAGS   = 64,
  parameter int META_WIDTH = 128
) (
  input  logic                  clock,
  input  logic                  rstn,
  input  logic                  enabled,
  input  logic                  alloc_req,
  input  logic [META_WIDTH-1:0] alloc_meta,
  output logic                  alloc_gnt,
  output logic [TAG_WIDTH-1:0]  alloc_tag,
  input  logic                  rel_valid,
  input  logic [TAG_WIDTH-1:0]  rel_tag,
  input  logic                  rel_tag_parity,
  output logic                  rel_meta_valid,
  output logic [META_WIDTH-1:0] rel_meta,
  output logic [TAG_WIDTH-1:0]  rel_tag_out,
  output logic                  tag_ready,
  output logic [TAG_WIDTH:0]    free_count,
  output logic                  init_done,
  output logic                  err_release,
  output logic                  err_parity
);
  localparam int PW = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
  localparam logic [PW-1:0]      LAST = PW'(NUM_TAGS - 1);
  localparam logic [TAG_WIDTH:0] NT   = (TAG_WIDTH+1)'(NUM_TAGS);

  typedef enum logic [1:0] {S_RESET, S_INIT, S_READY} state_t;
  state_t state, state_nxt;

  logic [TAG_WIDTH-1:0]  fifo_mem [NUM_TAGS];
  logic [META_WIDTH-1:0] meta_mem [NUM_TAGS];
  logic [NUM_TAGS-1:0]   inflight;
  logic [PW-1:0]         rd_ptr, wr_ptr, alloc_idx, rel_idx;
  logic [TAG_WIDTH-1:0]  head_tag, push_tag;
  logic is_ready, in_init, init_last, push;
  logic rel_in_range, rel_hit, rel_ok, rel_bad, par_ok, par_bad;

`ifdef TAG_POOL_PARITY_EN
  // Odd parity: tag bits plus parity bit must hold an odd number of ones.
  assign par_ok = ^{rel_tag, rel_tag_parity};
`else
  logic unused_parity;
  assign unused_parity = rel_tag_parity;
  assign par_ok        = 1'b1;
`endif

  assign is_ready  = (state == S_READY);
  assign in_init   = (state == S_INIT);
  assign init_last = in_init && (wr_ptr == LAST);
  assign init_done = is_ready;
  assign tag_ready = is_ready && (free_count != '0);
  // Grant looks only at the registered count, so a same-cycle release cannot feed it.
  assign alloc_gnt = alloc_req && tag_ready;
  assign head_tag  = fifo_mem[rd_ptr];
  assign alloc_tag = tag_ready ? head_tag : '0;
  assign alloc_idx = head_tag[PW-1:0];

  assign rel_idx      = rel_tag[PW-1:0];
  assign rel_in_range = ({1'b0, rel_tag} < NT);
  assign rel_hit      = rel_in_range && inflight[rel_idx];
  assign rel_ok       = rel_valid && is_ready && par_ok && rel_hit;
  assign rel_bad      = rel_valid && (!is_ready || (par_ok && !rel_hit));
  assign par_bad      = rel_valid && is_ready && !par_ok;

  assign push     = enabled && (in_init || rel_ok);
  assign push_tag = in_init ? TAG_WIDTH'(wr_ptr) : rel_tag;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) state <= S_RESET;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_RESET: if (enabled) state_nxt = S_INIT;
      S_INIT:  if (init_last) state_nxt = S_READY;
      S_READY: state_nxt = S_READY;
      default: state_nxt = S_RESET;
    endcase
    if (!enabled) state_nxt = S_RESET;
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      free_count     <= '0;
      inflight       <= '0;
      rel_meta_valid <= 1'b0;
      rel_meta       <= '0;
      rel_tag_out    <= '0;
    end else if (!enabled) begin
      // Leaving the pool drops every outstanding tag; INIT rebuilds from scratch.
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      free_count     <= '0;
      inflight       <= '0;
      rel_meta_valid <= 1'b0;
    end else begin
      rel_meta_valid <= rel_ok;
      if (rel_ok) begin
        rel_meta    <= meta_mem[rel_idx];
        rel_tag_out <= rel_tag;
      end
      if (push)      wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (alloc_gnt) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({push, alloc_gnt})
        2'b10:   free_count <= free_count + 1'b1;
        2'b01:   free_count <= free_count - 1'b1;
        default: free_count <= free_count;
      endcase
      if (alloc_gnt) inflight[alloc_idx] <= 1'b1;
      if (rel_ok)    inflight[rel_idx]   <= 1'b0;
    end
  end

  // Error flags survive enabled drops; only rstn clears them.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      err_release <= 1'b0;
      err_parity  <= 1'b0;
    end else begin
      err_release <= err_release | rel_bad;
      err_parity  <= err_parity | par_bad;
    end
  end

  always_ff @(posedge clock) begin
    if (push)      fifo_mem[wr_ptr]    <= push_tag;
    if (alloc_gnt) meta_mem[alloc_idx] <= alloc_meta;
  end

endmodule

// File: tb/tb_tag_pool_ctrl.sv
// Scoreboard bench for tag_pool_ctrl: a queue-based pool model predicts grants and
// released metadata; a negedge monitor pops and compares whenever the DUT presents them.
module tb_tag_pool_ctrl;
  localparam int TW = 8, NT = 64, MW = 128;

  logic          clock = 0, rstn = 1, enabled = 0;
  logic          alloc_req = 0, rel_valid = 0, rel_tag_parity = 0;
  logic [MW-1:0] alloc_meta = '0;
  logic [TW-1:0] rel_tag = '0;
  logic          alloc_gnt, rel_meta_valid, tag_ready, init_done, err_release, err_parity;
  logic [TW-1:0] alloc_tag, rel_tag_out;
  logic [MW-1:0] rel_meta;
  logic [TW:0]   free_count;

  always #5 clock = ~clock;

  tag_pool_ctrl #(.TAG_WIDTH(TW), .NUM_TAGS(NT), .META_WIDTH(MW)) dut (
    .clock(clock), .rstn(rstn), .enabled(enabled),
    .alloc_req(alloc_req), .alloc_meta(alloc_meta), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
    .rel_valid(rel_valid), .rel_tag(rel_tag), .rel_tag_parity(rel_tag_parity),
    .rel_meta_valid(rel_meta_valid), .rel_meta(rel_meta), .rel_tag_out(rel_tag_out),
    .tag_ready(tag_ready), .free_count(free_count), .init_done(init_done),
    .err_release(err_release), .err_parity(err_parity));

  typedef struct { int tag; logic [MW-1:0] meta; } rel_t;

  int            total = 0, bad = 0;
  int            exp_gnt[$];
  rel_t          exp_rel[$];
  int            free_q[$];
  bit            infl[NT];
  logic [MW-1:0] meta_m[NT];
  bit            m_ready, m_err_rel, m_err_par;

  task automatic chk(input string nm, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic bit par(input logic [TW-1:0] t);
    return ~^t;
  endfunction

  function automatic logic [MW-1:0] rnd_meta();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  always @(negedge clock) begin : mon
    rel_t e;
    if (rstn) begin
      if (alloc_gnt) begin
        if (exp_gnt.size() == 0) chk("unexpected_gnt", alloc_gnt, 0);
        else                     chk("gnt_tag", alloc_tag, exp_gnt.pop_front());
      end
      if (rel_meta_valid) begin
        if (exp_rel.size() == 0) chk("unexpected_rel", rel_meta_valid, 0);
        else begin
          e = exp_rel.pop_front();
          chk("rel_tag_out", rel_tag_out, e.tag);
          chk("rel_meta", rel_meta, e.meta);
        end
      end
    end
  end

  // One clock of stimulus, called at posedge+1; model state advances after the edge.
  task automatic cyc(input bit req, input logic [MW-1:0] meta, input bit rv, input int rt, input bit rp);
    bit g, ok, pok;
    int t;
    alloc_req = req; alloc_meta = meta;
    rel_valid = rv; rel_tag = rt[TW-1:0]; rel_tag_parity = rp;
    g   = req && m_ready && free_q.size() > 0;
    pok = 1'b1;
`ifdef TAG_POOL_PARITY_EN
    pok = (rp == par(rt[TW-1:0]));
`endif
    ok = rv && m_ready && pok && rt < NT && infl[rt];
    if (g)  exp_gnt.push_back(free_q[0]);
    if (ok) exp_rel.push_back('{rt, meta_m[rt]});
    if (rv && (!m_ready || (pok && !ok))) m_err_rel = 1'b1;
    if (rv && m_ready && !pok)            m_err_par = 1'b1;
    @(posedge clock); #1;
    if (g) begin
      t = free_q.pop_front();
      infl[t] = 1'b1;
      meta_m[t] = meta;
    end
    if (ok) begin
      infl[rt] = 1'b0;
      free_q.push_back(rt);
    end
    alloc_req = 0; rel_valid = 0;
    chk("free_count", free_count, free_q.size());
    chk("err_release", err_release, m_err_rel);
    chk("err_parity", err_parity, m_err_par);
  endtask

  task automatic idle();
    cyc(0, '0, 0, 0, 0);
  endtask

  task automatic drain();
    idle();
    chk("gnt_drain", exp_gnt.size(), 0);
    chk("rel_drain", exp_rel.size(), 0);
  endtask

  task automatic do_reset();
    rstn = 0; enabled = 0; alloc_req = 0; rel_valid = 0;
    #3;
    chk("rst_alloc_gnt", alloc_gnt, 0);
    chk("rst_alloc_tag", alloc_tag, 0);
    chk("rst_rel_meta_valid", rel_meta_valid, 0);
    chk("rst_rel_meta", rel_meta, 0);
    chk("rst_rel_tag_out", rel_tag_out, 0);
    chk("rst_tag_ready", tag_ready, 0);
    chk("rst_free_count", free_count, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_err_release", err_release, 0);
    chk("rst_err_parity", err_parity, 0);
    m_ready = 0; m_err_rel = 0; m_err_par = 0;
    free_q.delete(); exp_gnt.delete(); exp_rel.delete();
    foreach (infl[i]) infl[i] = 1'b0;
    @(posedge clock); #1;
    rstn = 1;
  endtask

  task automatic do_init();
    int n;
    n = 0;
    enabled = 1;
    do begin
      @(posedge clock); #1;
      n++;
    end while (!init_done && n < 200);
    chk("init_done", init_done, 1);
    chk("init_latency_in_range", (n >= NT && n <= NT + 1), 1);
    chk("init_free_count", free_count, NT);
    chk("init_alloc_tag", alloc_tag, 0);
    chk("init_tag_ready", tag_ready, 1);
    for (int i = 0; i < NT; i++) free_q.push_back(i);
    m_ready = 1;
  endtask

  task automatic rnd_traffic(input int cycles);
    int cand[$];
    int rt;
    bit rp;
    for (int n = 0; n < cycles; n++) begin
      cand.delete();
      for (int i = 0; i < NT; i++) if (infl[i]) cand.push_back(i);
      if (cand.size() == 0 || $urandom_range(0, 9) == 0) rt = int'($urandom_range(0, 255));
      else rt = cand[$urandom_range(0, cand.size() - 1)];
      rp = par(rt[TW-1:0]);
      if ($urandom_range(0, 15) == 0) rp = ~rp;
      cyc($urandom_range(0, 9) < 6, rnd_meta(), $urandom_range(0, 2) != 0, rt, rp);
    end
  endtask

  initial begin
    do_reset();
    do_init();

    // Drain the whole pool; tag 5 carries a recognisable metadata pattern.
    for (int i = 0; i < NT; i++) cyc(1, (i == 5) ? {16{8'hA5}} : rnd_meta(), 0, 0, 0);
    chk("empty_tag_ready", tag_ready, 0);
    cyc(1, rnd_meta(), 0, 0, 0);
    cyc(0, '0, 1, 5, par(8'd5));
    drain();

    // Empty pool: release and request collide, grant comes a cycle later.
    cyc(1, rnd_meta(), 0, 0, 0);
    cyc(1, rnd_meta(), 1, 9, par(8'd9));
    cyc(1, rnd_meta(), 0, 0, 0);
    drain();

    cyc(0, '0, 1, 7, par(8'd7));
    cyc(0, '0, 1, 7, par(8'd7));
    drain();

    cyc(0, '0, 1, 3, ~par(8'd3));
    drain();

    rnd_traffic(400);
    drain();

    rnd_traffic(30);
    do_reset();
    cyc(0, '0, 1, 3, par(8'd3));
    do_init();
    rnd_traffic(200);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
